seven_seg_scanner: RTL and testbench



---
 rtl/seven_seg_scanner.sv | 131 +++++++++++++
 tb/tb_seven_seg_scanner.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/seven_seg_scanner.sv
// seven_seg_scanner: digit-multiplex scan controller for a seven-segment
// display driver. A packed BCD value is captured into a shadow buffer and
// moved into the active buffer only at a frame boundary, so a frame is never
// torn. One digit index plus its nibble is presented per scan slot.
//
// Optional feature: define SEVEN_SEG_SCANNER_LZB_EN to enable leading-zero
// blanking. Leading zero digits above digit 0 are then emitted as BLANK_CODE.
// Digit 0 is never blanked.

module seven_seg_scanner #(
  parameter int         DIGIT_COUNT = 8,
  parameter int         CLK_HZ      = 100000000,
  parameter int         REFRESH_HZ  = 1000,
  parameter logic [3:0] BLANK_CODE  = 4'hF
) (
  input  logic                           clkIn,
  input  logic                           rstIn,
  input  logic                           enIn,
  input  logic                           loadIn,
  input  logic [4*DIGIT_COUNT-1:0]       valueIn,
  output logic [$clog2(DIGIT_COUNT)-1:0] selOut,
  output logic [3:0]                     bcdOut,
  output logic                           pendingOut,
  output logic                           loadAckOut,
  output logic                           frameOut
);

  localparam int TICK_DIV = CLK_HZ / REFRESH_HZ;
  localparam int SEL_W    = $clog2(DIGIT_COUNT);
  localparam int CNT_W    = $clog2(TICK_DIV);
  localparam int VAL_W    = 4 * DIGIT_COUNT;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TICK_DIV - 1);
  localparam logic [SEL_W-1:0] SEL_LAST = SEL_W'(DIGIT_COUNT - 1);

  logic [CNT_W-1:0]       preCnt;
  logic [CNT_W-1:0]       preNext;
  logic                   tick;
  logic                   frameEnd;
  logic                   swap;
  logic [SEL_W-1:0]       selNext;

  logic [VAL_W-1:0]       activeBuf;
  logic [VAL_W-1:0]       activeNext;
  logic [VAL_W-1:0]       shadowBuf;
  logic [VAL_W-1:0]       shadowNext;
  logic                   pendingNext;

  logic [DIGIT_COUNT-1:0] blankMask;
  logic                   upperZero;
  logic [3:0]             bcdNext;

  // Prescaler, slot tick and digit index stepping; all hold while disabled.
  always_comb begin
    tick     = enIn && (preCnt == CNT_LAST);
    frameEnd = tick && (selOut == SEL_LAST);

    preNext = preCnt;
    if (enIn) begin
      if (tick) preNext = '0;
      else      preNext = preCnt + CNT_W'(1);
    end

    selNext = selOut;
    if (tick) begin
      if (selOut == SEL_LAST) selNext = '0;
      else                    selNext = selOut + SEL_W'(1);
    end
  end

  // Double-buffer handshake: capture into shadow, swap into active at frame end.
  // A load landing on the frame-end cycle bypasses the shadow into active.
  always_comb begin
    swap        = frameEnd && (pendingOut || loadIn);
    shadowNext  = loadIn ? valueIn : shadowBuf;
    activeNext  = activeBuf;
    pendingNext = pendingOut;
    if (swap) begin
      activeNext  = loadIn ? valueIn : shadowBuf;
      pendingNext = 1'b0;
    end else if (loadIn) begin
      pendingNext = 1'b1;
    end
  end

  // Blank mask derived from the next active value so it tracks bcdOut exactly.
  always_comb begin
    upperZero = 1'b1;
    blankMask = '0;
`ifdef SEVEN_SEG_SCANNER_LZB_EN
    for (int k = DIGIT_COUNT - 1; k >= 0; k--) begin
      upperZero    = upperZero && (activeNext[4*k +: 4] == 4'h0);
      blankMask[k] = upperZero && (k != 0);
    end
`endif
  end

  // Digit mux evaluated on next-state values so selOut and bcdOut never skew.
  always_comb begin
    bcdNext = 4'h0;
    for (int k = 0; k < DIGIT_COUNT; k++) begin
      if (selNext == SEL_W'(k)) begin
        bcdNext = blankMask[k] ? BLANK_CODE : activeNext[4*k +: 4];
      end
    end
  end

  // State register; reset wins over everything and drops any pending load.
  always_ff @(posedge clkIn) begin
    if (rstIn) begin
      preCnt     <= '0;
      selOut     <= '0;
      bcdOut     <= 4'h0;
      activeBuf  <= '0;
      shadowBuf  <= '0;
      pendingOut <= 1'b0;
      loadAckOut <= 1'b0;
      frameOut   <= 1'b0;
    end else begin
      preCnt     <= preNext;
      selOut     <= selNext;
      bcdOut     <= bcdNext;
      activeBuf  <= activeNext;
      shadowBuf  <= shadowNext;
      pendingOut <= pendingNext;
      loadAckOut <= swap;
      frameOut   <= frameEnd;
    end
  end

endmodule

// File: tb/tb_seven_seg_scanner.sv
// tb_seven_seg_scanner: directed bench for seven_seg_scanner with
// DIGIT_COUNT=4, TICK_DIV=4. Leading-zero expectations follow
// SEVEN_SEG_SCANNER_LZB_EN when it is defined for the build.

module tb_seven_seg_scanner;

`ifdef SEVEN_SEG_SCANNER_LZB_EN
  localparam logic [3:0] EXP_BLANK = 4'hF;
`else
  localparam logic [3:0] EXP_BLANK = 4'h0;
`endif

  logic        clkIn = 1'b0;
  logic        rstIn;
  logic        enIn;
  logic        loadIn;
  logic [15:0] valueIn;
  logic [1:0]  selOut;
  logic [3:0]  bcdOut;
  logic        pendingOut;
  logic        loadAckOut;
  logic        frameOut;

  int assertCount = 0;
  int failCount   = 0;
  int edgeN       = 0;
  int ackSeen     = 0;

  seven_seg_scanner #(
    .DIGIT_COUNT(4),
    .CLK_HZ     (8),
    .REFRESH_HZ (2),
    .BLANK_CODE (4'hF)
  ) dut (
    .clkIn     (clkIn),
    .rstIn     (rstIn),
    .enIn      (enIn),
    .loadIn    (loadIn),
    .valueIn   (valueIn),
    .selOut    (selOut),
    .bcdOut    (bcdOut),
    .pendingOut(pendingOut),
    .loadAckOut(loadAckOut),
    .frameOut  (frameOut)
  );

  always #5 clkIn = ~clkIn;

  task automatic checkVal(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    assertCount++;
    if (obs !== exp) begin
      failCount++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock; edgeN counts enabled, non-reset edges since reset release.
  task automatic step();
    logic en;
    logic rst;
    en  = enIn;
    rst = rstIn;
    @(negedge clkIn);
    if (en && !rst) edgeN++;
  endtask

  task automatic stepTo(input int target);
    int guard;
    guard = 0;
    while (edgeN < target && guard < 500) begin
      step();
      guard++;
    end
    if (edgeN != target) checkVal("stepTo_timeout", edgeN, target);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    rstIn   = 1'b1;
    enIn    = 1'b0;
    loadIn  = 1'b0;
    valueIn = 16'h0;
    step();
    step();
    checkVal("rst_sel",     selOut,     0);
    checkVal("rst_bcd",     bcdOut,     0);
    checkVal("rst_pending", pendingOut, 0);
    checkVal("rst_ack",     loadAckOut, 0);
    checkVal("rst_frame",   frameOut,   0);

    // Scan sequence: each slot held 4 cycles, frame pulse every 16 with sel=0.
    rstIn = 1'b0;
    enIn  = 1'b1;
    edgeN = 0;
    for (int i = 0; i < 20; i++) begin
      step();
      checkVal("scan_sel",   selOut,   (edgeN / 4) % 4);
      checkVal("scan_frame", frameOut, (edgeN % 16 == 0) ? 1 : 0);
      checkVal("scan_bcd",   bcdOut,   0);
    end

    // Mid-frame load at sel=1, swap at next wrap (edge 32).
    loadIn  = 1'b1;
    valueIn = 16'h4321;
    step();
    loadIn = 1'b0;
    checkVal("ld_pending_set", pendingOut, 1);
    checkVal("ld_no_early_ack", loadAckOut, 0);
    stepTo(31);
    checkVal("ld_pending_hold", pendingOut, 1);
    checkVal("ld_sel3", selOut, 3);
    checkVal("ld_bcd_old", bcdOut, 0);
    stepTo(32);
    checkVal("ld_ack",     loadAckOut, 1);
    checkVal("ld_frame",   frameOut,   1);
    checkVal("ld_sel0",    selOut,     0);
    checkVal("ld_bcd_d0",  bcdOut,     1);
    checkVal("ld_pending_clr", pendingOut, 0);
    stepTo(33);
    checkVal("ld_ack_single", loadAckOut, 0);
    stepTo(36); checkVal("ld_bcd_d1", bcdOut, 2);
    stepTo(40); checkVal("ld_bcd_d2", bcdOut, 3);
    stepTo(44); checkVal("ld_bcd_d3", bcdOut, 4);
    stepTo(48);
    checkVal("ld_bcd_wrap", bcdOut, 1);
    checkVal("ld_ack_wrap", loadAckOut, 0);

    // Merged loads: 1111 then 9876 while pending; one ack at edge 64.
    loadIn  = 1'b1;
    valueIn = 16'h1111;
    step();
    loadIn  = 1'b0;
    ackSeen = 0;
    while (edgeN < 80) begin
      if (edgeN == 54) begin
        loadIn  = 1'b1;
        valueIn = 16'h9876;
      end
      step();
      loadIn = 1'b0;
      if (loadAckOut) ackSeen++;
      case (edgeN)
        55: checkVal("mrg_pending", pendingOut, 1);
        63: checkVal("mrg_bcd_old", bcdOut, 4);
        64: begin
          checkVal("mrg_ack", loadAckOut, 1);
          checkVal("mrg_d0", bcdOut, 6);
        end
        68: checkVal("mrg_d1", bcdOut, 7);
        72: checkVal("mrg_d2", bcdOut, 8);
        76: checkVal("mrg_d3", bcdOut, 9);
        default: ;
      endcase
    end
    checkVal("mrg_ack_count", ackSeen, 1);

    // Load on the exact frame-end tick (edge 96): direct swap.
    stepTo(95);
    loadIn  = 1'b1;
    valueIn = 16'h0505;
    step();
    loadIn = 1'b0;
    checkVal("fe_ack",     loadAckOut, 1);
    checkVal("fe_pending", pendingOut, 0);
    checkVal("fe_sel",     selOut,     0);
    checkVal("fe_bcd",     bcdOut,     5);
    checkVal("fe_frame",   frameOut,   1);
    step();
    checkVal("fe_pending_after", pendingOut, 0);
    checkVal("fe_ack_after",     loadAckOut, 0);
    stepTo(100); checkVal("fe_d1", bcdOut, 0);
    stepTo(104); checkVal("fe_d2", bcdOut, 5);

    // Disable for 10 cycles at sel=2 with one count of the slot used.
    stepTo(121);
    checkVal("dis_pre_sel", selOut, 2);
    checkVal("dis_pre_bcd", bcdOut, 5);
    enIn = 1'b0;
    for (int i = 0; i < 10; i++) begin
      if (i == 5) begin
        loadIn  = 1'b1;
        valueIn = 16'h0070;
      end
      step();
      loadIn = 1'b0;
      checkVal("dis_sel",   selOut,     2);
      checkVal("dis_bcd",   bcdOut,     5);
      checkVal("dis_frame", frameOut,   0);
      checkVal("dis_ack",   loadAckOut, 0);
    end
    checkVal("dis_pending", pendingOut, 1);
    enIn = 1'b1;
    stepTo(123);
    checkVal("res_sel_hold", selOut, 2);
    stepTo(124);
    checkVal("res_sel_next", selOut, 3);
    checkVal("res_pending",  pendingOut, 1);

    // Reset while pending discards the load.
    rstIn = 1'b1;
    step();
    rstIn = 1'b0;
    edgeN = 0;
    checkVal("rp_sel",     selOut,     0);
    checkVal("rp_bcd",     bcdOut,     0);
    checkVal("rp_pending", pendingOut, 0);
    checkVal("rp_ack",     loadAckOut, 0);
    checkVal("rp_frame",   frameOut,   0);
    for (int i = 0; i < 20; i++) begin
      step();
      checkVal("rp_no_ack", loadAckOut, 0);
      checkVal("rp_bcd_zero", bcdOut, 0);
    end

    // Leading-zero behaviour with 0070, then all zeros.
    loadIn  = 1'b1;
    valueIn = 16'h0070;
    step();
    loadIn = 1'b0;
    stepTo(32);
    checkVal("lz_ack", loadAckOut, 1);
    checkVal("lz_d0",  bcdOut,     0);
    stepTo(36); checkVal("lz_d1", bcdOut, 7);
    stepTo(40); checkVal("lz_d2", bcdOut, EXP_BLANK);
    stepTo(44); checkVal("lz_d3", bcdOut, EXP_BLANK);
    loadIn  = 1'b1;
    valueIn = 16'h0000;
    step();
    loadIn = 1'b0;
    stepTo(48);
    checkVal("lz0_ack", loadAckOut, 1);
    checkVal("lz0_d0",  bcdOut,     0);
    stepTo(52); checkVal("lz0_d1", bcdOut, EXP_BLANK);
    stepTo(56); checkVal("lz0_d2", bcdOut, EXP_BLANK);
    stepTo(60); checkVal("lz0_d3", bcdOut, EXP_BLANK);

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
